// File: rtl/kalman_forecast.sv
// Kalman predict (time-update) stage for one axis, shared between roll and pitch.
// It captures X(t-1), P(t-1) and the gyro rate, then produces the a-priori X and P.
module kalman_forecast #(
  parameter logic signed [31:0] DT      = 32'sd328,
  parameter logic signed [31:0] Q_ANGLE = 32'sd66,
  parameter logic signed [31:0] Q_BIAS  = 32'sd197
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               forecast_en_in,
  input  logic signed [31:0] gyro_in,
  input  logic signed [31:0] angle_t_1_in,
  input  logic signed [31:0] bias_t_1_in,
  input  logic signed [31:0] P_0_0_t_1_in,
  input  logic signed [31:0] P_0_1_t_1_in,
  input  logic signed [31:0] P_1_0_t_1_in,
  input  logic signed [31:0] P_1_1_t_1_in,
  output logic signed [31:0] angle_p_out,
  output logic signed [31:0] bias_p_out,
  output logic signed [31:0] P_0_0_p_out,
  output logic signed [31:0] P_0_1_p_out,
  output logic signed [31:0] P_1_0_p_out,
  output logic signed [31:0] P_1_1_p_out,
  output logic               forecast_done_out,
  output logic               busy_out
);

  typedef enum logic [2:0] {StIdle, StRate, StMul1, StMul2, StMul3, StDone} state_e;

  state_e state_q;
  logic   en_d_q;

  logic signed [31:0] gyro_q, angle_q, bias_q;
  logic signed [31:0] p00_q, p01_q, p10_q, p11_q;
  logic signed [31:0] rate_q, dt_rate_q, dt_p11_q, qb_dt_q;
  logic signed [31:0] angle_n_q, s_q, p01_n_q, p10_n_q, p11_n_q;

  // Q16.16 multiply: bits [47:16] of the full signed product, i.e. an arithmetic
  // shift that floors toward -inf, truncated to 32 bits without saturation.
  function automatic logic signed [31:0] mul(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    return 32'(({{32{a[31]}}, a} * {{32{b[31]}}, b}) >> 16);
  endfunction

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q           <= StIdle;
      en_d_q            <= 1'b0;
      gyro_q            <= '0;
      angle_q           <= '0;
      bias_q            <= '0;
      p00_q             <= '0;
      p01_q             <= '0;
      p10_q             <= '0;
      p11_q             <= '0;
      rate_q            <= '0;
      dt_rate_q         <= '0;
      dt_p11_q          <= '0;
      qb_dt_q           <= '0;
      angle_n_q         <= '0;
      s_q               <= '0;
      p01_n_q           <= '0;
      p10_n_q           <= '0;
      p11_n_q           <= '0;
      angle_p_out       <= '0;
      bias_p_out        <= '0;
      P_0_0_p_out       <= '0;
      P_0_1_p_out       <= '0;
      P_1_0_p_out       <= '0;
      P_1_1_p_out       <= '0;
      forecast_done_out <= 1'b0;
      busy_out          <= 1'b0;
    end else begin
      en_d_q            <= forecast_en_in;
      forecast_done_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Only a fresh rising edge starts a run; a held level never restarts.
          if (forecast_en_in && !en_d_q) begin
            gyro_q   <= gyro_in;
            angle_q  <= angle_t_1_in;
            bias_q   <= bias_t_1_in;
            p00_q    <= P_0_0_t_1_in;
            p01_q    <= P_0_1_t_1_in;
            p10_q    <= P_1_0_t_1_in;
            p11_q    <= P_1_1_t_1_in;
            busy_out <= 1'b1;
            state_q  <= StRate;
          end
        end
        StRate: begin
          rate_q  <= gyro_q - bias_q;
          state_q <= StMul1;
        end
        StMul1: begin
          dt_rate_q <= mul(DT, rate_q);
          dt_p11_q  <= mul(DT, p11_q);
          qb_dt_q   <= mul(Q_BIAS, DT);
          state_q   <= StMul2;
        end
        StMul2: begin
          angle_n_q <= angle_q + dt_rate_q;
          s_q       <= dt_p11_q - p01_q - p10_q + Q_ANGLE;
          p01_n_q   <= p01_q - dt_p11_q;
          p10_n_q   <= p10_q - dt_p11_q;
          p11_n_q   <= p11_q + qb_dt_q;
          state_q   <= StMul3;
        end
        StMul3: begin
          angle_p_out       <= angle_n_q;
          bias_p_out        <= bias_q;
          P_0_0_p_out       <= p00_q + mul(DT, s_q);
          P_0_1_p_out       <= p01_n_q;
          P_1_0_p_out       <= p10_n_q;
          P_1_1_p_out       <= p11_n_q;
          forecast_done_out <= 1'b1;
          state_q           <= StDone;
        end
        StDone: begin
          busy_out <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_kalman_forecast.sv
// Self-checking bench for kalman_forecast: vector table plus scoreboard of expected
// outputs popped on every done pulse, and hand sequences for timing corner cases.
module tb_kalman_forecast;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               forecast_en_in;
  logic signed [31:0] gyro_in, angle_t_1_in, bias_t_1_in;
  logic signed [31:0] P_0_0_t_1_in, P_0_1_t_1_in, P_1_0_t_1_in, P_1_1_t_1_in;
  logic signed [31:0] angle_p_out, bias_p_out;
  logic signed [31:0] P_0_0_p_out, P_0_1_p_out, P_1_0_p_out, P_1_1_p_out;
  logic               forecast_done_out, busy_out;

  kalman_forecast dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .forecast_en_in    (forecast_en_in),
    .gyro_in           (gyro_in),
    .angle_t_1_in      (angle_t_1_in),
    .bias_t_1_in       (bias_t_1_in),
    .P_0_0_t_1_in      (P_0_0_t_1_in),
    .P_0_1_t_1_in      (P_0_1_t_1_in),
    .P_1_0_t_1_in      (P_1_0_t_1_in),
    .P_1_1_t_1_in      (P_1_1_t_1_in),
    .angle_p_out       (angle_p_out),
    .bias_p_out        (bias_p_out),
    .P_0_0_p_out       (P_0_0_p_out),
    .P_0_1_p_out       (P_0_1_p_out),
    .P_1_0_p_out       (P_1_0_p_out),
    .P_1_1_p_out       (P_1_1_p_out),
    .forecast_done_out (forecast_done_out),
    .busy_out          (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic signed [31:0] angle, bias, p00, p01, p10, p11;
  } exp_t;

  typedef struct {
    logic signed [31:0] angle, bias, gyro, p00, p01, p10, p11;
    exp_t               e;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_done   = 0;

  localparam exp_t IdentExp = '{32'sd3280, 32'sd0, 32'sd65537, -32'sd328, -32'sd328, 32'sd65536};

  task automatic check(input bit ok, input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", nm, $signed(act), act,
                  $signed(req), req);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (forecast_done_out) begin
      n_done++;
      if (sb.size() == 0) begin
        check(1'b0, "unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(angle_p_out == e.angle, "angle_p", angle_p_out, e.angle);
        check(bias_p_out == e.bias, "bias_p", bias_p_out, e.bias);
        check(P_0_0_p_out == e.p00, "P00p", P_0_0_p_out, e.p00);
        check(P_0_1_p_out == e.p01, "P01p", P_0_1_p_out, e.p01);
        check(P_1_0_p_out == e.p10, "P10p", P_1_0_p_out, e.p10);
        check(P_1_1_p_out == e.p11, "P11p", P_1_1_p_out, e.p11);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic signed [31:0] a, b, g, p00, p01, p10, p11);
    angle_t_1_in = a;
    bias_t_1_in  = b;
    gyro_in      = g;
    P_0_0_t_1_in = p00;
    P_0_1_t_1_in = p01;
    P_1_0_t_1_in = p10;
    P_1_1_t_1_in = p11;
  endtask

  task automatic drive_ident();
    drive(32'sd0, 32'sd0, 32'sd655360, 32'sd65536, 32'sd0, 32'sd0, 32'sd65536);
  endtask

  // Called in the start cycle; returns in the cycle where done should be high.
  task automatic expect_done_at(input int lat, input string nm);
    int first;
    bit busy_ok;
    first   = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      tick();
      if (forecast_done_out && first < 0) first = i;
      if (!busy_out) busy_ok = 1'b0;
    end
    check(first == lat, {nm, "_latency"}, 32'(first), 32'(lat));
    check(busy_ok, {nm, "_busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic check_zero_outs(input string nm);
    check(angle_p_out == 0 && bias_p_out == 0 && P_0_0_p_out == 0 && P_0_1_p_out == 0 &&
          P_1_0_p_out == 0 && P_1_1_p_out == 0 && !forecast_done_out && !busy_out,
          nm, angle_p_out | P_0_0_p_out | P_1_1_p_out | 32'(busy_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   d0;

    vecs[0] = '{32'sd0, 32'sd0, 32'sd655360, 32'sd65536, 32'sd0, 32'sd0, 32'sd65536, IdentExp};
    vecs[1] = '{32'sd0, 32'sd0, -32'sd1, 32'sd65536, 32'sd0, 32'sd0, 32'sd65536,
                '{-32'sd1, 32'sd0, 32'sd65537, -32'sd328, -32'sd328, 32'sd65536}};
    vecs[2] = '{32'sd0, 32'sd0, 32'sd1, 32'sd65536, 32'sd0, 32'sd0, 32'sd65536,
                '{32'sd0, 32'sd0, 32'sd65537, -32'sd328, -32'sd328, 32'sd65536}};
    vecs[3] = '{32'sd65536, 32'sd65536, 32'sd131072, 32'sd131072, 32'sd1000, 32'sd2000,
                32'sd131072,
                '{32'sd65864, 32'sd65536, 32'sd131060, 32'sd344, 32'sd1344, 32'sd131072}};
    vecs[4] = '{-32'sd65536, -32'sd32768, -32'sd163840, 32'sd0, 32'sd0, 32'sd0, 32'sd0,
                '{-32'sd66192, -32'sd32768, 32'sd0, 32'sd0, 32'sd0, 32'sd0}};

    rst_in         = 1'b1;
    forecast_en_in = 1'b0;
    drive_ident();
    tick();
    tick();
    check_zero_outs("reset_outs");
    rst_in = 1'b0;
    tick();
    check_zero_outs("post_reset_outs");
    d0 = n_done;
    repeat (20) tick();
    check(n_done == d0, "idle_no_done", 32'(n_done - d0), 32'd0);

    // Table runs, back to back: each new rise lands in the IDLE cycle after DONE.
    for (int v = 0; v < 5; v++) begin
      drive(vecs[v].angle, vecs[v].bias, vecs[v].gyro, vecs[v].p00, vecs[v].p01,
            vecs[v].p10, vecs[v].p11);
      forecast_en_in = 1'b1;
      sb.push_back(vecs[v].e);
      expect_done_at(5, $sformatf("vec%0d", v));
      forecast_en_in = 1'b0;
      tick();
      check(!busy_out && !forecast_done_out, $sformatf("vec%0d_drop", v),
            32'({busy_out, forecast_done_out}), 32'd0);
    end

    // Held en: exactly one done over 12 cycles.
    repeat (3) tick();
    drive_ident();
    forecast_en_in = 1'b1;
    sb.push_back(IdentExp);
    d0 = n_done;
    repeat (12) tick();
    check(n_done - d0 == 1, "held_en_one_done", 32'(n_done - d0), 32'd1);
    forecast_en_in = 1'b0;
    tick();
    forecast_en_in = 1'b1;
    sb.push_back(IdentExp);
    expect_done_at(5, "retrigger");
    forecast_en_in = 1'b0;
    repeat (3) tick();

    // Rising edge inside MUL1 is dropped.
    d0 = n_done;
    forecast_en_in = 1'b1;
    sb.push_back(IdentExp);
    tick();
    forecast_en_in = 1'b0;
    tick();
    forecast_en_in = 1'b1;
    repeat (15) tick();
    check(n_done - d0 == 1, "mul1_edge_ignored", 32'(n_done - d0), 32'd1);
    forecast_en_in = 1'b0;
    repeat (2) tick();

    // Capture isolation: scramble inputs during RATE and MUL1.
    drive_ident();
    forecast_en_in = 1'b1;
    sb.push_back(IdentExp);
    tick();
    drive(32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
          32'($urandom), 32'($urandom));
    tick();
    drive(32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
          32'($urandom), 32'($urandom));
    forecast_en_in = 1'b0;
    repeat (3) tick();
    check(forecast_done_out == 1'b1, "isolation_done", 32'(forecast_done_out), 32'd1);
    repeat (3) tick();

    // Reset during MUL2 aborts without a done pulse and clears the outputs.
    drive(32'sd65536, 32'sd65536, 32'sd131072, 32'sd131072, 32'sd1000, 32'sd2000, 32'sd131072);
    forecast_en_in = 1'b1;
    d0 = n_done;
    tick();
    tick();
    tick();
    rst_in         = 1'b1;
    forecast_en_in = 1'b0;
    #2;
    check_zero_outs("midrun_reset_outs");
    #2;
    rst_in = 1'b0;
    repeat (8) tick();
    check(n_done == d0, "aborted_no_done", 32'(n_done - d0), 32'd0);
    check_zero_outs("aborted_outs_hold");
    drive_ident();
    forecast_en_in = 1'b1;
    sb.push_back(IdentExp);
    expect_done_at(5, "after_reset");
    forecast_en_in = 1'b0;
    repeat (4) tick();
    check(sb.size() == 0, "sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
